// File: rtl/rvvi_net_event_queue.sv
// +------------------------------------------------------------------------+
// | rvvi_net_event_queue                                                   |
// | Net-change detector with round-robin stamping into a drainable FIFO.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module rvvi_net_event_queue #(
  parameter  int NCHAN = 4,
  parameter  int VW    = 64,
  parameter  int DEPTH = 8,
  localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCHAN-1:0]    net_en,
  input  logic [NCHAN*VW-1:0] net_value,
  input  logic                pop_ready,
  output logic                pop_valid,
  output logic [CW-1:0]       pop_chan,
  output logic [VW-1:0]       pop_value,
  output logic [63:0]         pop_slot,
  output logic [63:0]         pop_order,
  output logic [AW:0]         count,
  output logic                full,
  output logic [63:0]         vslot,
  output logic [15:0]         coalesced
);

  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] c_last  = CW'(NCHAN-1);

  logic [VW-1:0]    r_shadow [NCHAN];
  logic [VW-1:0]    r_pval   [NCHAN];
  logic [63:0]      r_pslot  [NCHAN];
  logic [NCHAN-1:0] r_pend;
  logic [CW-1:0]    r_ptr;
  logic [63:0]      r_vslot;
  logic [63:0]      r_order;
  logic [15:0]      r_coal;
  logic [AW:0]      r_count;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;

  logic [CW-1:0]    r_m_chan  [DEPTH];
  logic [VW-1:0]    r_m_value [DEPTH];
  logic [63:0]      r_m_slot  [DEPTH];
  logic [63:0]      r_m_order [DEPTH];

  logic [NCHAN-1:0] w_chg;
  logic [NCHAN-1:0] w_take;
  logic             w_gnt_vld;
  logic [CW-1:0]    w_gnt;
  int               w_idx;
  logic             w_pop;
  logic             w_push;
  logic [7:0]       w_coal_n;
  logic [16:0]      w_coal_sum;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    assign w_chg[i]  = net_en[i] && (net_value[i*VW +: VW] != r_shadow[i]);
    assign w_take[i] = w_push && (w_gnt == CW'(i));
  end

  // First pending channel at or after the round-robin pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = 0;
    for (int k = 0; k < NCHAN; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NCHAN) w_idx = w_idx - NCHAN;
      if (!w_gnt_vld && r_pend[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CW'(w_idx);
      end
    end
  end

  assign w_pop  = pop_valid && pop_ready;
  assign w_push = w_gnt_vld && ((r_count != c_depth) || w_pop);

  // A change on a still-pending, ungranted channel overwrites the older sample.
  always_comb begin
    w_coal_n = '0;
    for (int i = 0; i < NCHAN; i++)
      if (r_pend[i] && w_chg[i] && !w_take[i]) w_coal_n = w_coal_n + 8'd1;
  end
  assign w_coal_sum = {1'b0, r_coal} + {9'd0, w_coal_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vslot <= '0;
      r_order <= '0;
      r_coal  <= '0;
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_ptr   <= '0;
      r_pend  <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        r_shadow[i] <= '0;
        r_pval[i]   <= '0;
        r_pslot[i]  <= '0;
      end
    end else begin
      r_vslot <= r_vslot + 64'd1;
      for (int i = 0; i < NCHAN; i++) begin
        if (w_chg[i]) begin
          r_shadow[i] <= net_value[i*VW +: VW];
          r_pval[i]   <= net_value[i*VW +: VW];
          r_pslot[i]  <= r_vslot;
        end
        r_pend[i] <= w_chg[i] || (r_pend[i] && !w_take[i]);
      end
      if (w_push) begin
        r_order <= r_order + 64'd1;
        r_wr    <= r_wr + 1'b1;
        r_ptr   <= (w_gnt == c_last) ? '0 : w_gnt + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      r_coal <= w_coal_sum[16] ? 16'hFFFF : w_coal_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_m_chan[r_wr]  <= w_gnt;
      r_m_value[r_wr] <= r_pval[w_gnt];
      r_m_slot[r_wr]  <= r_pslot[w_gnt];
      r_m_order[r_wr] <= r_order;
    end
  end

  assign pop_valid = (r_count != '0);
  assign pop_chan  = pop_valid ? r_m_chan[r_rd]  : '0;
  assign pop_value = pop_valid ? r_m_value[r_rd] : '0;
  assign pop_slot  = pop_valid ? r_m_slot[r_rd]  : '0;
  assign pop_order = pop_valid ? r_m_order[r_rd] : '0;
  assign count     = r_count;
  assign full      = (r_count == c_depth);
  assign vslot     = r_vslot;
  assign coalesced = r_coal;

endmodule

`default_nettype wire

// File: doc/rvvi_net_event_queue.md
Name: rvvi_net_event_queue

Overview:
- Hardware successor to the RVVI trace net-synchronisation queue.
- Watches NCHAN net channels of parameterised width and detects changes against a per-channel shadow copy.
- Stamps each change with the free-running trace slot and a gap-free sequence number, then buffers it in a DEPTH-entry FIFO.
- Sits between DUT-side net probes and the RVVI trace consumer. Provides fair arbitration, coalescing under back-pressure, and valid/ready drain.

Parameters:
- NCHAN, 4, number of monitored net channels (1..64).
- VW, 64, value width per channel in bits (1..64).
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CW, $clog2(NCHAN) (min 1), channel-id width; derived, not overridable.

Ports:
- clk  input  1  interface clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- net_en  input  NCHAN  per-channel sample strobe.
- net_value  input  NCHAN*VW  channel i occupies bits [i*VW +: VW].
- pop_ready  input  1  consumer accepts the head entry.
- pop_valid  output  1  head entry present.
- pop_chan  output  CW  channel id of the head entry.
- pop_value  output  VW  value of the head entry.
- pop_slot  output  64  vslot at which the change was sampled.
- pop_order  output  64  sequence number of the head entry.
- count  output  $clog2(DEPTH)+1  occupied FIFO entries.
- full  output  1  count == DEPTH.
- vslot  output  64  free-running slot counter.
- coalesced  output  16  saturating count of overwritten pending events.

Behaviour:
- Reset (async assert, sync release): vslot=0, order counter=0, shadows=0, pending=0, round-robin pointer=0, FIFO empty, count=0, coalesced=0. Outputs: pop_valid=0, full=0, pop_chan/value/slot/order=0. Reset mid-operation discards all pending and queued events.
- vslot increments by 1 every cycle and wraps modulo 2^64.
- Change detect, channel i at edge k: triggers when net_en[i]=1 and net_value[i] != shadow[i].
  - shadow[i] <= net_value[i].
  - pending[i] <= 1, with captured value and slot = vslot before edge k.
  - If net_en[i]=0 or the value is unchanged, nothing happens for that channel.
- Arbiter:
  - Each cycle, grants at most one pending channel, round-robin starting at the pointer.
  - After a grant to channel g, the pointer becomes (g+1) mod NCHAN.
  - A write is allowed when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
  - Granted entry carries {chan, value, slot, order}; the order counter then increments (64-bit, wraps). Orders are contiguous, with no gaps or reuse.
- Pending update rules for channel i:
  - Granted with no new change: pending[i] clears.
  - Granted and a new change in the same cycle: pending[i] stays 1 with the new value/slot. No coalesce.
  - Not granted while pending, with a new change: value/slot overwritten and coalesced increments, saturating at 16'hFFFF.
- FIFO:
  - Head is presented combinationally from storage: pop_valid = (count != 0).
  - Pop occurs when pop_valid && pop_ready. pop_ready while empty has no effect.
  - Simultaneous push and pop leaves count unchanged; this also holds when full.
  - Pointers wrap modulo DEPTH.
  - Head outputs hold stable while pop_valid=1 and pop_ready=0.
- Latency: with no contention, a change sampled at edge k sets pending at edge k. The FIFO write happens at edge k+1, and pop_valid=1 after edge k+1 (two-edge detect-to-visible).
- Event order in the FIFO follows grant order, not sample order, across channels. Per channel, sample order is always preserved.

Test Plan:
- Reset, hold rst_n=0 for 3 cycles then release; net_en=0 for 5 cycles -> pop_valid=0, count=0, vslot=5, coalesced=0.
- Channel 2 changes to 0x1234 at vslot=10, pop_ready=1 -> after two edges, pop_valid=1, pop_chan=2, pop_value=0x1234, pop_slot=10, pop_order=0; entry popped on the next edge.
- All 4 channels change in the same cycle, pointer=0 -> FIFO receives chan 0,1,2,3 on consecutive cycles with orders 0..3. A later simultaneous change on 1 and 3 grants 1 then 3 (pointer at 0 after wrap, then 2).
- pop_ready=0 and 8 changes fill the FIFO (full=1). Channel 0 then changes three times (0xA, 0xB, 0xC) while full -> coalesced=2. After one pop, channel 0 entry has value 0xC and its last sample slot.
- Full FIFO, pop_ready=1 with a pending channel -> push and pop in the same cycle, count stays 8, and orders remain contiguous.
- Same value re-driven with net_en=1, or a change driven with net_en=0 -> no event. Async reset asserted mid-drain -> pop_valid drops immediately and count=0.
